// File: rtl/uart_tx_fifo_if.sv
// Bus between the CSR write port / status readback and the UART transmitter
// holding register, as seen by the TX byte FIFO.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovrflw;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          tx_wr;
  logic [7:0]    tx_wdata;
  logic          tx_tbr_valid;

  modport slave (
    input  wr_en, wr_data, clr_ovrflw, tx_tbr_valid,
    output full, empty, level, overflow, tx_wr, tx_wdata
  );

  modport master (
    output wr_en, wr_data, clr_ovrflw, tx_tbr_valid,
    input  full, empty, level, overflow, tx_wr, tx_wdata
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers CSR UART-TX writes and hands them to the transmitter
// holding register one at a time, with registered full/empty/level/overflow status.
//
// state | meaning
// IDLE  | waiting for a queued byte and a free holding register
// SEND  | byte loaded this cycle; wait for the transmitter to show busy
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int            LW      = AW + 1;
  localparam logic [AW:0]   LVL_MAX = LW'(DEPTH);
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_SEND = 1'b1;

  logic [7:0]  mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_wdata_q, tx_wdata_d;
  logic [0:0]    state_q, state_d;

  logic          pop;
  logic          push_ok;
  logic          drop;

  always_comb begin
    pop     = (state_q == ST_IDLE) && (level_q != '0) && !bus.tx_tbr_valid;
    // A push into a full FIFO still fits when a byte leaves on the same edge.
    push_ok = bus.wr_en && (!full_q || pop);
    drop    = bus.wr_en && full_q && !pop;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    full_d  = (level_d == LVL_MAX);
    empty_d = (level_d == '0);

    if (drop)
      ovf_d = 1'b1;
    else if (bus.clr_ovrflw)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;

    tx_wr_d    = pop;
    tx_wdata_d = pop ? mem_q[rd_ptr_q] : tx_wdata_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop)              state_d = ST_SEND;
      ST_SEND: if (bus.tx_tbr_valid) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_wdata_q <= 8'h00;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      tx_wr_q    <= tx_wr_d;
      tx_wdata_q <= tx_wdata_d;
      state_q    <= state_d;
    end
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok)
      mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
  assign bus.tx_wr    = tx_wr_q;
  assign bus.tx_wdata = tx_wdata_q;

endmodule
